// File: rtl/result_streamer_pkg.sv
// Shared constants and types for the result streamer: memory geometry,
// drain FSM states and the tagged beat carried through the skid FIFO.
package result_streamer_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 7;
  localparam int TILE_ELEMS = 16;
  localparam int MAX_TILES  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [2:0]        tile;
    logic [3:0]        idx;
    logic              last;
  } beat_t;
endpackage

// File: rtl/result_streamer_if.sv
// Valid/ready result stream: one 32-bit element per beat with tile/element tags.
interface result_streamer_if;
  import result_streamer_pkg::*;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [2:0]        m_tile;
  logic [3:0]        m_idx;
  logic              m_last;

  modport master (output m_valid, m_data, m_tile, m_idx, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_tile, m_idx, m_last, output m_ready);
endinterface

// File: rtl/result_skid_fifo.sv
// Two-entry FIFO with a registered head so the stream outputs come straight from flops.
module result_skid_fifo
  import result_streamer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  beat_t      din,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] count
);

  beat_t      head_q, head_d;
  beat_t      tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       pop_ok;

  assign pop_ok = pop && (count_q != 2'd0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d  = din;
          count_d = 2'd1;
        end else begin
          tail_d  = din;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps the occupancy; the head advances.
        if (count_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  // The head drives the output bus, so it is cleared along with the occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    tail_q <= tail_d;
  end

  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/result_streamer.sv
// Drains result tiles from the 1-cycle-latency output memory onto a tagged
// valid/ready stream; reads are credit-limited so the 2-entry FIFO never overflows.
module result_streamer
  import result_streamer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        num_tiles,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  result_streamer_if.master m
);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [ADDR_W:0]   end_q, end_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [3:0]        n_clamp;
  logic [1:0]        fifo_count;
  logic              fifo_valid;
  logic              pop;
  logic [2:0]        occ;
  beat_t             fifo_din;
  beat_t             fifo_head;

  assign n_clamp    = (num_tiles > 4'(MAX_TILES)) ? 4'(MAX_TILES) : num_tiles;
  assign fifo_valid = (fifo_count != 2'd0);
  assign pop        = fifo_valid && m.m_ready;

  // Occupancy after this cycle's pop and the in-flight push land.
  assign occ    = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign mem_rd = (state_q == FETCH) && (occ < 3'd2);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    end_d   = end_q;
    tag_d   = mem_rd ? addr_q[ADDR_W-1:0] : tag_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          end_d   = {n_clamp, 4'b0000} - (ADDR_W+1)'(1);
          // An empty run still spends one busy cycle so done lands at t+2.
          state_d = (n_clamp == 4'd0) ? DRAIN : FETCH;
        end
      end
      FETCH: begin
        if (mem_rd) begin
          addr_d = addr_q + (ADDR_W+1)'(1);
          if (addr_q == end_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (occ == 3'd0) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      end_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      end_q      <= end_d;
      inflight_q <= mem_rd;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign fifo_din.data = mem_data;
  assign fifo_din.tile = tag_q[6:4];
  assign fifo_din.idx  = tag_q[3:0];
  assign fifo_din.last = (tag_q[3:0] == 4'(TILE_ELEMS-1));

  result_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (fifo_din),
    .pop   (pop),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign busy     = (state_q == FETCH) || (state_q == DRAIN);
  assign done     = (state_q == FIN);
  assign mem_addr = addr_q[ADDR_W-1:0];

  assign m.m_valid = fifo_valid;
  assign m.m_data  = fifo_head.data;
  assign m.m_tile  = fifo_head.tile;
  assign m.m_idx   = fifo_head.idx;
  assign m.m_last  = fifo_head.last;

endmodule
